// File: rtl/craft_pkg.sv
// Shared CRAFT constants, tweak permutation and tweakey FSM state type.
// Pure definitions; no timing or flow control of its own.
package craft_pkg;

  localparam int          CRAFT_ROUNDS = 32;
  localparam logic [3:0]  RC_A_LAST    = 4'h8;
  localparam logic [2:0]  RC_B_LAST    = 3'h5;

  // Nibble j of this constant (nibble 0 = MSB) is the source index Q[j].
  localparam logic [63:0] Q_TABLE      = 64'hCAF5_E892_B374_601D;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STREAM,
    ST_DONE
  } state_t;

  function automatic logic [63:0] q_perm(input logic [63:0] t);
    logic [63:0] r;
    logic [3:0]  qi;
    r = '0;
    for (int j = 0; j < 16; j++) begin
      qi = Q_TABLE[63-4*j -: 4];
      r[63-4*j -: 4] = t[63-4*int'(qi) -: 4];
    end
    return r;
  endfunction

  // Rows are nibbles 0-3, 4-7, 8-11, 12-15 of the 64-bit state.
  function automatic logic [63:0] mix_column(input logic [63:0] t);
    logic [63:0] r;
    r = t;
    r[63:48] = t[63:48] ^ t[31:16] ^ t[15:0];
    r[47:32] = t[47:32] ^ t[15:0];
    return r;
  endfunction

endpackage

// File: rtl/craft_dec_tweakey_stream_if.sv
// Nibble stream from the tweakey generator to the serial decryption core.
// Valid/ready handshake; producer holds all fields while ready is low.
interface craft_dec_tweakey_stream_if;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out;
  logic [7:0] rc;
  logic [4:0] round;
  logic       last;

  modport master (output out_valid, out, rc, round, last, input out_ready);
  modport slave  (input out_valid, out, rc, round, last, output out_ready);
endinterface

// File: rtl/craft_rc_lfsr_inv.sv
// Round-constant LFSR pair stepped backwards (round 31 towards 0).
// Updates on load/step the cycle they are asserted; no backpressure of its own.
module craft_rc_lfsr_inv
  import craft_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       step,
  output logic [3:0] a,
  output logic [2:0] b,
  output logic [7:0] rc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a <= 4'h0;
      b <= 3'h0;
    end else if (load) begin
      a <= RC_A_LAST;
      b <= RC_B_LAST;
    end else if (step) begin
      a <= {a[2:0], a[3] ^ a[0]};
      b <= {b[1:0], b[2] ^ b[0]};
    end
  end

  assign rc = {a, 1'b0, b};

endmodule

// File: rtl/craft_dec_tweakey_stream.sv
// CRAFT decryption round-tweakey generator: rounds 31..0, 16 nibbles each; CRAFT_DEC_MC_TK_EN adds MixColumn.
// 1 LOAD bubble + 16 handshakes per round; out_ready low stalls with all outputs held.
module craft_dec_tweakey_stream
  import craft_pkg::*;
#(
  parameter int ROUNDS = CRAFT_ROUNDS
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [127:0]                      key,
  input  logic [63:0]                       tweak,
  output logic                              busy,
  output logic                              done,
  craft_dec_tweakey_stream_if.master        tk_if
);

  state_t       state, state_nxt;
  logic [127:0] key_q;
  logic [63:0]  tweak_q;
  logic [63:0]  sreg;
  logic [63:0]  tk;
  logic [3:0]   cnt;
  logic [4:0]   round_q;
  logic [3:0]   rc_a;
  logic [2:0]   rc_b;
  logic [7:0]   rc;
  logic         init, load, step, hs;

  assign hs = (state == ST_STREAM) && tk_if.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    init      = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          init      = 1'b1;
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        load      = 1'b1;
        state_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        if (hs && cnt == 4'hF) begin
          if (round_q != 5'd0) begin
            step      = 1'b1;
            state_nxt = ST_LOAD;
          end else begin
            state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Even rounds take K0, and rounds with bit 1 set use the permuted tweak.
  always_comb begin
    tk = (round_q[0] ? key_q[63:0] : key_q[127:64]) ^
         (round_q[1] ? q_perm(tweak_q) : tweak_q);
    tk[47:44] = tk[47:44] ^ rc_a;
    tk[43:40] = tk[43:40] ^ {1'b0, rc_b};
`ifdef CRAFT_DEC_MC_TK_EN
    tk = mix_column(tk);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q   <= '0;
      tweak_q <= '0;
      sreg    <= '0;
      cnt     <= 4'h0;
      round_q <= 5'd0;
    end else begin
      if (init) begin
        key_q   <= key;
        tweak_q <= tweak;
        round_q <= 5'(ROUNDS - 1);
      end
      if (load) begin
        sreg <= tk;
        cnt  <= 4'h0;
      end
      if (hs) begin
        sreg <= {sreg[59:0], 4'h0};
        cnt  <= cnt + 4'd1;
        if (cnt == 4'hF && round_q != 5'd0) round_q <= round_q - 5'd1;
      end
    end
  end

  craft_rc_lfsr_inv u_rc (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (init),
    .step  (step),
    .a     (rc_a),
    .b     (rc_b),
    .rc    (rc)
  );

  assign tk_if.out_valid = (state == ST_STREAM);
  assign tk_if.out       = sreg[63:60];
  assign tk_if.rc        = rc;
  assign tk_if.round     = round_q;
  assign tk_if.last      = (state == ST_STREAM) && (round_q == 5'd0) && (cnt == 4'hF);
  assign busy            = (state != ST_IDLE);
  assign done            = (state == ST_DONE);

endmodule

// File: tb/tb_craft_dec_tweakey_stream.sv
// Bench for the CRAFT decryption tweakey stream: reference model from nibble arithmetic,
// directed constant checks, random key/tweak, random stalls and reset mid-stream.
module tb_craft_dec_tweakey_stream;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] key;
  logic [63:0]  tweak;
  logic         busy, done;

  craft_dec_tweakey_stream_if tk_if ();

  craft_dec_tweakey_stream dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .key   (key),
    .tweak (tweak),
    .busy  (busy),
    .done  (done),
    .tk_if (tk_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected {out, rc, round, last} for each of the 512 stream positions.
  logic [17:0] exp_v   [512];
  logic [3:0]  obs_nib [512];
  logic [7:0]  obs_rc  [512];
  logic [3:0]  ref_nib [512];
  int          qt      [16] = '{12, 10, 15, 5, 14, 8, 9, 2, 11, 3, 7, 4, 6, 0, 1, 13};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic build_model(input logic [127:0] k, input logic [63:0] t);
    int         a, b, pos;
    logic [3:0] tn [16];
    logic [3:0] tkn [16];
    logic [63:0] kv;
    a = 8;
    b = 5;
    for (int i = 0; i < 16; i++) tn[i] = t[63-4*i -: 4];
    for (int r = 31; r >= 0; r--) begin
      kv = (r % 2 == 0) ? k[127:64] : k[63:0];
      for (int j = 0; j < 16; j++)
        tkn[j] = kv[63-4*j -: 4] ^ ((r % 4 < 2) ? tn[j] : tn[qt[j]]);
      tkn[4] = tkn[4] ^ 4'(a);
      tkn[5] = tkn[5] ^ 4'(b);
`ifdef CRAFT_DEC_MC_TK_EN
      for (int c = 0; c < 4; c++) begin
        tkn[c]     = tkn[c] ^ tkn[8+c] ^ tkn[12+c];
        tkn[4+c]   = tkn[4+c] ^ tkn[12+c];
      end
`endif
      for (int j = 0; j < 16; j++) begin
        pos = (31 - r) * 16 + j;
        exp_v[pos] = {tkn[j], 4'(a), 1'b0, 3'(b), 5'(r), (r == 0 && j == 15)};
      end
      a = ((a << 1) & 14) | (((a >> 3) ^ a) & 1);
      b = ((b << 1) & 6)  | (((b >> 2) ^ b) & 1);
    end
  endtask

  function automatic logic [63:0] pack_round(input int r);
    logic [63:0] v;
    for (int j = 0; j < 16; j++) v[63-4*j -: 4] = obs_nib[(31-r)*16 + j];
    return v;
  endfunction

  // Starts one full stream and consumes it; done_cyc = edges from start acceptance to done.
  task automatic run(input logic [127:0] k, input logic [63:0] t, input int stall_pct,
                     input bit poke_start, output int done_cyc);
    int idx, cyc;
    bit rdy, seen;
    build_model(k, t);
    key = k;
    tweak = t;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    key = {$urandom, $urandom, $urandom, $urandom};
    tweak = {$urandom, $urandom};
    idx = 0;
    cyc = 0;
    seen = 1'b0;
    done_cyc = -1;
    while (!seen && cyc < 4000) begin
      check("busy", busy, 1'b1);
      if (tk_if.out_valid) begin
        // all-ones is unreachable (rc bit 3 is always 0), so overrun is caught
        check("nibble", {tk_if.out, tk_if.rc, tk_if.round, tk_if.last},
              (idx < 512) ? exp_v[idx] : 18'h3FFFF);
      end
      if (done) begin
        start = 1'b0;
        seen = 1'b1;
        done_cyc = cyc;
        check("nibble_count", idx, 512);
      end else begin
        rdy = (stall_pct == 0) ? 1'b1 : ($urandom_range(99) >= stall_pct);
        tk_if.out_ready = rdy;
        if (tk_if.out_valid && rdy && idx < 512) begin
          obs_nib[idx] = tk_if.out;
          obs_rc[idx]  = tk_if.rc;
          idx++;
        end
        if (poke_start) begin
          start = ($urandom_range(3) == 0);
          key = {$urandom, $urandom, $urandom, $urandom};
          tweak = {$urandom, $urandom};
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    start = 1'b0;
    tk_if.out_ready = 1'b1;
    check("done_seen", seen, 1'b1);
    @(posedge clk); #1;
    check("done_pulse_idle", {done, busy, tk_if.out_valid}, 3'b000);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc, n, diffs;
    logic [127:0] rk;
    logic [63:0]  rt;

    rst_n = 1'b0;
    start = 1'b0;
    key = '0;
    tweak = '0;
    tk_if.out_ready = 1'b0;
    #1;
    check("reset_state", {tk_if.out_valid, tk_if.out, tk_if.rc, tk_if.round,
                          tk_if.last, busy, done}, 0);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;

    // all-zero key and tweak
    run(128'h0, 64'h0, 0, 1'b0, dc);
    check("latency_done", dc, 544);
`ifndef CRAFT_DEC_MC_TK_EN
    check("zero_r31", pack_round(31), 64'h0000_8500_0000_0000);
    check("zero_r0",  pack_round(0),  64'h0000_1100_0000_0000);
`endif
    check("zero_rc31", obs_rc[0],   8'h85);
    check("zero_rc0",  obs_rc[496], 8'h11);

    // K0 all ones: only even rounds see it
    run({64'hFFFF_FFFF_FFFF_FFFF, 64'h0}, 64'h0, 0, 1'b0, dc);
    check("latency_k0", dc, 544);
`ifndef CRAFT_DEC_MC_TK_EN
    check("k0_r31", pack_round(31), 64'h0000_8500_0000_0000);
    check("k0_r30", pack_round(30), 64'hFFFF_EDFF_FFFF_FFFF);
`endif
    check("k0_rc30", obs_rc[16], 8'h12);

    // counting tweak exposes the permutation
    run(128'h0, 64'h0123_4567_89AB_CDEF, 0, 1'b0, dc);
`ifndef CRAFT_DEC_MC_TK_EN
    check("tw_r31", pack_round(31), 64'hCAF5_6D92_B374_601D);
    check("tw_r29", pack_round(29) & 64'hFFFF_FFF0_0000_000F, 64'h0123_7160_0000_000F);
`endif
    check("tw_rc29", obs_rc[32], 8'h34);

    // random key/tweak, unstalled, then stalled with start pokes while busy
    rk = {$urandom, $urandom, $urandom, $urandom};
    rt = {$urandom, $urandom};
    run(rk, rt, 0, 1'b0, dc);
    check("latency_rand", dc, 544);
    for (int i = 0; i < 512; i++) ref_nib[i] = obs_nib[i];
    run(rk, rt, 40, 1'b1, dc);
    diffs = 0;
    for (int i = 0; i < 512; i++) if (obs_nib[i] !== ref_nib[i]) diffs++;
    check("stall_identical", diffs, 0);

    // reset asserted in the middle of round 17
    key = {$urandom, $urandom, $urandom, $urandom};
    tweak = {$urandom, $urandom};
    tk_if.out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!(tk_if.out_valid && tk_if.round == 5'd17) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_r17", (n < 2000), 1'b1);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midstream_reset", {tk_if.out_valid, tk_if.out, tk_if.rc, tk_if.round,
                              tk_if.last, busy, done}, 0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_idle", {busy, tk_if.out_valid}, 2'b00);

    rk = {$urandom, $urandom, $urandom, $urandom};
    rt = {$urandom, $urandom};
    run(rk, rt, 25, 1'b1, dc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
